bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd_seq_ctrl.sv | 90 +++++++++
 tb/tb_bcd_seq_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_STEPS = 8;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) dout = din + 4'd3;
    end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3), one bit per cycle,
// with a valid/ready request port and a valid/ready result port.
module bcd_seq_ctrl
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] binary_in,
    output logic       out_valid,
    input  logic       out_ready,
    output bcd_digit_t hundreds,
    output bcd_digit_t tens,
    output bcd_digit_t units
);

    localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

    state_t      state, state_nxt;
    logic [7:0]  shift_reg;
    logic [11:0] digits;
    logic [2:0]  step;
    logic [11:0] digits_adj;
    logic [19:0] shifted;
    logic        last_step;

    for (genvar g = 0; g < 3; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (digits[g*4 +: 4]),
            .dout (digits_adj[g*4 +: 4])
        );
    end

    assign shifted   = {digits_adj, shift_reg} << 1;
    assign last_step = (step == LAST_STEP);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only move on the final shift, so they hold the previous
    // answer throughout IDLE and SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            digits    <= '0;
            step      <= '0;
            hundreds  <= '0;
            tens      <= '0;
            units     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= binary_in;
                        digits    <= '0;
                        step      <= '0;
                    end
                end
                SHIFT: begin
                    digits    <= shifted[19:8];
                    shift_reg <= shifted[7:0];
                    step      <= step + 3'd1;
                    if (last_step) begin
                        hundreds <= shifted[19:16];
                        tens     <= shifted[15:12];
                        units    <= shifted[11:8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: expected digits come from a decimal reference
// model, queued on accept and popped when the result appears.
module tb_bcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] binary_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] hundreds, tens, units;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic [11:0] last_res;

    bcd_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .binary_in (binary_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hundreds  (hundreds),
        .tens      (tens),
        .units     (units)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [7:0] v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        binary_in = v;
        @(negedge clk);
        in_valid  = 1'b0;
        binary_in = 8'($urandom);
        exp_q.push_back(ref_bcd(int'(v)));
    endtask

    // Called at the negedge after an accept; waits for the result, optionally
    // stalls the consumer for 'hold' cycles, then completes the handshake.
    task automatic receive(input int hold);
        int          n = 0;
        logic [11:0] exp;
        out_ready = (hold == 0);
        check("held_result", {20'd0, hundreds, tens, units}, {20'd0, last_res});
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 8);
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else                   exp = 'x;
        check("result", {20'd0, hundreds, tens, units}, {20'd0, exp});
        last_res = exp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {20'd0, hundreds, tens, units}, {20'd0, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", {31'd0, out_valid}, 32'd0);
        check("ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        binary_in = 8'd0;
        last_res  = 12'h000;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_digits", {20'd0, hundreds, tens, units}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 255 with the consumer always ready
        send(8'd255);
        receive(0);

        // directed back-to-back values
        send(8'd0);   receive(0);
        send(8'd9);   receive(0);
        send(8'd10);  receive(0);
        send(8'd99);  receive(0);
        send(8'd100); receive(0);
        send(8'd128); receive(0);

        // consumer stall
        send(8'd173);
        receive(5);

        // in_valid held high through SHIFT/DONE with a different value
        send(8'd42);
        in_valid  = 1'b1;
        binary_in = 8'd200;
        receive(0);
        @(negedge clk);
        check("reaccept", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        exp_q.push_back(ref_bcd(200));
        receive(0);
        repeat (3) @(negedge clk);
        check("single_accept", {31'd0, in_ready}, 32'd1);

        // reset in the 4th SHIFT cycle discards the conversion
        send(8'd250);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_digits", {20'd0, hundreds, tens, units}, 32'd0);
        void'(exp_q.pop_back());
        last_res = 12'h000;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("no_stale_result", seen, 0);
        send(8'd7);
        receive(0);

        // exhaustive sweep
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            receive(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
